serial_adder: RTL
=================

Name: serial_adder

Overview:
- Bit-serial adder for WIDTH-bit operands; sits directly upstream of the existing 1-bit fullAdder cell.
- Each clock it feeds the fullAdder one operand bit pair plus a registered carry, then captures the fullAdder's sum and carry outputs.
- Trades WIDTH cycles of latency for one adder cell; used where area matters more than throughput.
- Start/busy/done handshake toward the controlling logic.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk, input, 1, single system clock; all state changes on its rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, request to begin an addition; sampled only when not busy.
- a, input, WIDTH, operand A; captured on the accepting edge.
- b, input, WIDTH, operand B; captured on the accepting edge.
- cin, input, 1, carry-in; captured on the accepting edge.
- busy, output, 1, high while an addition is in progress.
- done, output, 1, one-cycle pulse when sum/cout become valid.
- sum, output, WIDTH, result of a+b+cin modulo 2^WIDTH.
- cout, output, 1, carry out of bit WIDTH-1.

Behaviour:
- Reset (rst_n low, asynchronous, any time): state IDLE; busy=0, done=0, sum=0, cout=0; operand shift registers, carry register and bit counter cleared. Outputs hold these values until the first completion.
- States:
  - IDLE: start=1 -> load A_sh<=a, B_sh<=b, c_reg<=cin, cnt<=0; go to RUN.
  - RUN: each edge:
    - fullAdder inputs are A_sh[0], B_sh[0], c_reg.
    - Partial-sum register shifts right with fullAdder sum entering at MSB.
    - c_reg<=fullAdder carry; A_sh, B_sh shift right; cnt<=cnt+1.
    - On the edge where cnt==WIDTH-1, go to DONE; sum<=completed partial sum; cout<=final carry.
  - DONE: lasts exactly one cycle. start=1 is accepted exactly as in IDLE (load, go to RUN); otherwise go to IDLE.
- Combinational decodes:
  - busy = (state==RUN).
  - done = (state==DONE).
- Latency: if start is accepted on edge N, done is high in the cycle following edge N+WIDTH, and sum/cout are valid in that same cycle.
- sum and cout change only on the edge entering DONE. They hold the last result through IDLE, RUN and any subsequent accepted start until the next completion.
- start while busy is ignored; there is no queueing, and a, b, cin may change freely during RUN.
- Back-to-back operation: start held high continuously gives one result every WIDTH+1 cycles.
- Reset mid-RUN aborts the operation: no done pulse, sum/cout return to 0.
- Counter width is clog2(WIDTH). It never wraps within an operation.
- Arithmetic is unsigned; {cout,sum} == a+b+cin exactly.

Decomposition:
- Shared include file:
  - state encoding localparams: IDLE=2'd0, RUN=2'd1, DONE=2'd2; 2'd3 is unreachable and decodes to IDLE.
  - default WIDTH constant.
- One sub-module instance: the existing fullAdder (ports a, b, cin, sum, carry) as the per-bit datapath; no other hierarchy.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, cin=0, start pulsed on edge 0 -> busy high for 8 cycles, done pulse after edge 8, sum=0x96, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- start asserted during RUN with a=0x11, b=0x22 -> ignored; result still matches the first-accepted operands, exactly one done pulse.
- start held high continuously with operand pairs (0x01,0x01) then (0x80,0x80) -> done pulses 9 cycles apart; results 0x02/cout=0 then 0x00/cout=1.
- rst_n pulled low mid-RUN (after 4 bit-cycles) -> busy, done, sum, cout all 0 immediately; no done pulse; next start completes normally.
- WIDTH=4, exhaustive a, b, cin (512 cases) -> {cout,sum} equals a+b+cin for every case.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared state encoding and default width for the bit-serial adder
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // 2'd3 is never entered; the FSM treats it as IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_fa.sv
// rtl/serial_adder_fa.sv - 1-bit full adder cell used as the serial datapath
module serial_adder_fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder with start/busy/done handshake
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic [WIDTH-2:0] psum;
    logic [WIDTH-1:0] psum_full;
    logic             c_reg;
    logic [CW-1:0]    cnt;
    logic             load;
    logic             last;
    logic             fa_sum, fa_carry;

    serial_adder_fa u_fa (
        .a     (a_sh[0]),
        .b     (b_sh[0]),
        .cin   (c_reg),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    // Newest bit enters at the MSB, so after WIDTH shifts bit 0 sits at the LSB.
    assign psum_full = {fa_sum, psum};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        load      = 1'b0;
        last      = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            RUN: begin
                busy      = 1'b1;
                last      = (cnt == LAST);
                state_nxt = last ? DONE : RUN;
            end
            DONE: begin
                done      = 1'b1;
                load      = start;
                state_nxt = start ? RUN : IDLE;
            end
            default: begin
                load      = start;
                state_nxt = start ? RUN : IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            c_reg <= 1'b0;
            cnt   <= '0;
            psum  <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (load) begin
            a_sh  <= a;
            b_sh  <= b;
            c_reg <= cin;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
            c_reg <= fa_carry;
            psum  <= psum_full[WIDTH-1:1];
            if (last) begin
                sum  <= psum_full;
                cout <= fa_carry;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule
